// File: rtl/dso_pkg.sv
// Shared constants, FSM state type and address arithmetic for the DSO frame reader.
package dso_pkg;

  localparam int unsigned DSO_WAVE_DEPTH      = 1024;
  localparam int unsigned DSO_HALF_WAVE_DEPTH = DSO_WAVE_DEPTH >> 1;
  localparam int unsigned DSO_ADDR_W          = 12;
  localparam int unsigned DSO_DATA_W          = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } dso_state_e;

  // base + inc folded back into [0, depth) with a single subtraction; callers keep
  // base < depth and inc <= depth so one fold is always enough.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = base + inc;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

endpackage

// File: rtl/dso_buf_reader_if.sv
// Sample-RAM read port plus the outgoing valid/ready sample stream of the frame reader.
// master: the reader (drives RAM address/enable and the stream); slave: RAM + consumer.
interface dso_buf_reader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] ram_rd_addr;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output ram_rd_addr,
    output ram_rd_en,
    input  ram_rd_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  ram_rd_addr,
    input  ram_rd_en,
    output ram_rd_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );

endinterface

// File: rtl/dso_skid_buf.sv
// Two-entry valid/ready buffer for returning RAM words. Exposes its fill count so the
// reader can ration read issues and never overrun it.
module dso_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] w_head_d;
  logic [DATA_W-1:0] w_tail_d;
  logic [1:0]        w_cnt_d;
  logic              w_pop;

  assign w_pop   = i_pop && (r_cnt != 2'd0);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_cnt;

  // Next contents: head always holds the oldest word, tail the second.
  always_comb begin
    w_head_d = r_head;
    w_tail_d = r_tail;
    w_cnt_d  = r_cnt;
    if (i_flush) begin
      w_cnt_d = 2'd0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            w_head_d = i_data;
            w_cnt_d  = 2'd1;
          end else if (r_cnt == 2'd1) begin
            w_tail_d = i_data;
            w_cnt_d  = 2'd2;
          end
        end
        2'b01: begin
          w_head_d = r_tail;
          w_cnt_d  = r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            w_head_d = i_data;
          end else begin
            w_head_d = r_tail;
            w_tail_d = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage and fill count.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      r_head <= w_head_d;
      r_tail <= w_tail_d;
      r_cnt  <= w_cnt_d;
    end
  end

endmodule

// File: rtl/dso_buf_reader.sv
// Reads one captured frame out of the ADC sample RAM, starting half a frame before the
// trigger address (circular), and streams it over valid/ready with m_last on the final
// sample and a rd_done pulse afterwards.
// Optional build macro DSO_BUF_STATS_EN adds min/max/peak-to-peak of the streamed frame.
module dso_buf_reader
  import dso_pkg::*;
#(
  parameter int unsigned WAVE_DEPTH      = DSO_WAVE_DEPTH,
  parameter int unsigned HALF_WAVE_DEPTH = WAVE_DEPTH >> 1,
  parameter int unsigned ADDR_W          = DSO_ADDR_W,
  parameter int unsigned DATA_W          = DSO_DATA_W
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic              i_cap_done,
  input  logic [ADDR_W-1:0] i_trig_addr,
  input  logic              i_abort,
  output logic              o_rd_done,
  output logic              o_busy,
`ifdef DSO_BUF_STATS_EN
  output logic [DATA_W-1:0] o_stat_min,
  output logic [DATA_W-1:0] o_stat_max,
  output logic [DATA_W-1:0] o_stat_vpp,
  output logic              o_stat_valid,
`endif
  dso_buf_reader_if.master  io_bus
);

  localparam int unsigned      CNT_W    = $clog2(WAVE_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WAVE_DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(WAVE_DEPTH);

  dso_state_e        r_state;
  dso_state_e        w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_rd_vld;

  logic [ADDR_W:0]   w_trig_ext;
  logic [ADDR_W:0]   w_trig_mod;
  logic [ADDR_W-1:0] w_start;
  logic              w_start_frame;
  logic              w_issue;
  logic              w_credit_ok;
  logic [1:0]        w_used;
  logic              w_pop;
  logic              w_buf_valid;
  logic [DATA_W-1:0] w_buf_data;
  logic [1:0]        w_buf_cnt;

  // Pre-trigger start: fold the trigger address once into the frame, then step back half.
  assign w_trig_ext = {1'b0, i_trig_addr};
  assign w_trig_mod = (w_trig_ext >= DEPTH_X) ? (w_trig_ext - DEPTH_X) : w_trig_ext;
  assign w_start    = ADDR_W'(wrap_add(32'(w_trig_mod), WAVE_DEPTH - HALF_WAVE_DEPTH,
                                       WAVE_DEPTH));

  // Words that will occupy the buffer, net of this cycle's transfer. Counting the pop
  // keeps one read in flight per cycle while the 2-entry buffer can never overflow.
  assign w_pop       = w_buf_valid && io_bus.m_ready;
  assign w_used      = w_buf_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
  assign w_credit_ok = (w_used < 2'd2);

  // Frame sequencing and read issue; abort overrides everything.
  always_comb begin
    w_state_d     = r_state;
    w_issue       = 1'b0;
    w_start_frame = 1'b0;
    o_rd_done     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cap_done) begin
          w_start_frame = 1'b1;
          w_state_d     = StRead;
        end
      end
      StRead: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_issue_cnt == LAST_IDX) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (w_pop && (r_out_cnt == LAST_IDX)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        o_rd_done = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (i_abort) begin
      w_state_d     = StIdle;
      w_issue       = 1'b0;
      w_start_frame = 1'b0;
      o_rd_done     = 1'b0;
    end
  end

  // State register and read-return flag (RAM data is valid the cycle after the enable).
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_rd_vld <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rd_vld <= w_issue;
    end
  end

  // Read address and issue count: loaded with the frozen start, advanced per issue.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
    end else if (w_start_frame) begin
      r_addr      <= w_start;
      r_issue_cnt <= '0;
    end else if (w_issue) begin
      r_addr      <= ADDR_W'(wrap_add(32'(r_addr), 32'd1, WAVE_DEPTH));
      r_issue_cnt <= r_issue_cnt + CNT_W'(1);
    end
  end

  // Count of samples handed downstream this frame; drives m_last and the drain exit.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
    end else if (w_start_frame || i_abort) begin
      r_out_cnt <= '0;
    end else if (w_pop) begin
      r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  dso_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .ad_clk  (ad_clk),
    .rst_n   (rst_n),
    .i_flush (i_abort),
    .i_push  (r_rd_vld),
    .i_data  (io_bus.ram_rd_data),
    .i_pop   (w_pop),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_count (w_buf_cnt)
  );

  assign io_bus.ram_rd_en   = w_issue;
  assign io_bus.ram_rd_addr = r_addr;
  assign io_bus.m_valid     = w_buf_valid;
  assign io_bus.m_data      = w_buf_data;
  assign io_bus.m_last      = w_buf_valid && (r_out_cnt == LAST_IDX);
  assign o_busy             = (r_state != StIdle);

`ifdef DSO_BUF_STATS_EN
  logic [DATA_W-1:0] r_stat_min;
  logic [DATA_W-1:0] r_stat_max;

  // Running extremes over transferred samples, re-armed at each frame start.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_min <= '0;
      r_stat_max <= '0;
    end else if (w_start_frame) begin
      r_stat_min <= '1;
      r_stat_max <= '0;
    end else if (w_pop) begin
      if (w_buf_data < r_stat_min) begin
        r_stat_min <= w_buf_data;
      end
      if (w_buf_data > r_stat_max) begin
        r_stat_max <= w_buf_data;
      end
    end
  end

  assign o_stat_min   = r_stat_min;
  assign o_stat_max   = r_stat_max;
  assign o_stat_vpp   = r_stat_max - r_stat_min;
  assign o_stat_valid = o_rd_done;
`endif

endmodule

// File: tb/tb_dso_buf_reader.sv
// Self-checking bench for dso_buf_reader: table of frame scenarios plus random frames,
// checked against a frame-level model (expected address/sample order from start + i).
module tb_dso_buf_reader;

  localparam int unsigned DEPTH = 1024;

  logic        ad_clk = 1'b0;
  logic        rst_n;
  logic        cap_done;
  logic        abort;
  logic [11:0] trig_addr;
  logic        rd_done;
  logic        busy;
`ifdef DSO_BUF_STATS_EN
  logic [7:0]  stat_min;
  logic [7:0]  stat_max;
  logic [7:0]  stat_vpp;
  logic        stat_valid;
`endif

  always #5 ad_clk = ~ad_clk;

  dso_buf_reader_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  dso_buf_reader #(
    .WAVE_DEPTH      (1024),
    .HALF_WAVE_DEPTH (512),
    .ADDR_W          (12),
    .DATA_W          (8)
  ) dut (
    .ad_clk       (ad_clk),
    .rst_n        (rst_n),
    .i_cap_done   (cap_done),
    .i_trig_addr  (trig_addr),
    .i_abort      (abort),
    .o_rd_done    (rd_done),
    .o_busy       (busy),
`ifdef DSO_BUF_STATS_EN
    .o_stat_min   (stat_min),
    .o_stat_max   (stat_max),
    .o_stat_vpp   (stat_vpp),
    .o_stat_valid (stat_valid),
`endif
    .io_bus       (bus)
  );

  // Sample RAM with one-cycle read latency.
  logic [7:0] mem [DEPTH];
  always @(posedge ad_clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr[9:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] trig;
    bit          rnd_ready;
    int          exp_start;
    int          exp_lat;   // cycle of rd_done counted from the cap_done cycle; 0 = skip
    int          abort_at;  // abort during this transfer number; 0 = none
    bit          poke;      // disturb cap_done/trig_addr mid-frame
    int          data_mode; // 0: a[7:0], 1: random, 2: 20 + a % 211
  } vec_t;

  task automatic load_mem(input int mode);
    for (int a = 0; a < DEPTH; a++) begin
      if (mode == 1)      mem[a] = 8'($urandom);
      else if (mode == 2) mem[a] = 8'(20 + (a % 211));
      else                mem[a] = 8'(a);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int c, n_iss, n_out, exp_min, exp_max, ea;
    bit done, prev_stall;
    logic [7:0] prev_data;
    load_mem(v.data_mode);
    exp_min = 255; exp_max = 0;
    c = 0; n_iss = 0; n_out = 0; done = 0; prev_stall = 0; prev_data = '0;
    @(posedge ad_clk); #1;
    cap_done = 1'b1; trig_addr = v.trig; abort = 1'b0;
    bus.m_ready = v.rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
    #1;
    chk("busy_before_start", busy, 0);
    while (!done) begin
      @(posedge ad_clk); #1;
      c++;
      cap_done  = v.poke && (c >= 40) && (c < 44);
      trig_addr = (v.poke && (c >= 40)) ? 12'd7 : v.trig;
      bus.m_ready = v.rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
      abort = (v.abort_at != 0) && (n_out == v.abort_at - 1);
      #1;
      if (c == 1) chk("busy_after_start", busy, 1);
      if (!v.rnd_ready && c == 1) chk("rd_en_latency", bus.ram_rd_en, 1);
      if (!v.rnd_ready && c == 2) chk("m_valid_early", bus.m_valid, 0);
      if (!v.rnd_ready && c == 3) chk("m_valid_latency", bus.m_valid, 1);
      if (bus.ram_rd_en) begin
        if (n_iss >= DEPTH) chk("extra_issue", bus.ram_rd_en, 0);
        ea = (v.exp_start + n_iss) % DEPTH;
        chk("rd_addr", bus.ram_rd_addr, ea);
        chk("rd_addr_range", bus.ram_rd_addr < DEPTH, 1);
        n_iss++;
      end
      if (prev_stall) begin
        chk("valid_hold", bus.m_valid, 1);
        chk("data_hold", bus.m_data, prev_data);
      end
      if (bus.m_valid) begin
        chk("m_last", bus.m_last, n_out == DEPTH - 1);
        if (bus.m_ready) begin
          ea = (v.exp_start + n_out) % DEPTH;
          chk("m_data", bus.m_data, mem[ea]);
          if (mem[ea] < exp_min) exp_min = mem[ea];
          if (mem[ea] > exp_max) exp_max = mem[ea];
          n_out++;
        end
      end else begin
        chk("m_last_idle", bus.m_last, 0);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      if (abort) begin
        @(posedge ad_clk); #1;
        abort = 1'b0; cap_done = 1'b0;
        #1;
        chk("abort_valid", bus.m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", rd_done, 0);
        chk("abort_count", n_out, v.abort_at);
        for (int i = 0; i < 20; i++) begin
          @(posedge ad_clk); #1;
          chk("post_abort_done", rd_done, 0);
          chk("post_abort_valid", bus.m_valid, 0);
        end
        done = 1;
      end else if (rd_done) begin
        chk("frame_samples", n_out, DEPTH);
        chk("frame_issues", n_iss, DEPTH);
        chk("busy_in_done", busy, 1);
        if (v.exp_lat != 0) chk("done_latency", c, v.exp_lat);
`ifdef DSO_BUF_STATS_EN
        chk("stat_valid", stat_valid, 1);
        chk("stat_min", stat_min, exp_min);
        chk("stat_max", stat_max, exp_max);
        chk("stat_vpp", stat_vpp, exp_max - exp_min);
        if (v.data_mode == 2) begin
          chk("stat_min_range", stat_min, 20);
          chk("stat_max_range", stat_max, 230);
          chk("stat_vpp_range", stat_vpp, 210);
        end
`endif
        @(posedge ad_clk); #1;
        cap_done = 1'b0;
        #1;
        chk("done_pulse", rd_done, 0);
        chk("busy_after_done", busy, 0);
`ifdef DSO_BUF_STATS_EN
        chk("stat_valid_pulse", stat_valid, 0);
`endif
        done = 1;
      end else if (c > 8000) begin
        chk("frame_timeout", n_out, DEPTH);
        done = 1;
      end
    end
    cap_done = 1'b0;
    abort    = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    vec_t rv;
    int   rt;
    tbl[0] = '{trig: 12'd600,  rnd_ready: 0, exp_start: 88,  exp_lat: 1027, abort_at: 0,
               poke: 0, data_mode: 0};
    tbl[1] = '{trig: 12'd100,  rnd_ready: 0, exp_start: 612, exp_lat: 1027, abort_at: 0,
               poke: 0, data_mode: 0};
    tbl[2] = '{trig: 12'd1023, rnd_ready: 1, exp_start: 511, exp_lat: 0,    abort_at: 0,
               poke: 1, data_mode: 0};
    tbl[3] = '{trig: 12'd512,  rnd_ready: 0, exp_start: 0,   exp_lat: 1027, abort_at: 0,
               poke: 0, data_mode: 0};
    tbl[4] = '{trig: 12'd1500, rnd_ready: 0, exp_start: 988, exp_lat: 1027, abort_at: 0,
               poke: 0, data_mode: 0};
    tbl[5] = '{trig: 12'd300,  rnd_ready: 0, exp_start: 812, exp_lat: 0,    abort_at: 300,
               poke: 0, data_mode: 0};
    tbl[6] = '{trig: 12'd600,  rnd_ready: 1, exp_start: 88,  exp_lat: 0,    abort_at: 0,
               poke: 0, data_mode: 0};
    tbl[7] = '{trig: 12'd600,  rnd_ready: 0, exp_start: 88,  exp_lat: 1027, abort_at: 0,
               poke: 0, data_mode: 2};

    rst_n = 1'b0; cap_done = 1'b0; abort = 1'b0; trig_addr = '0; bus.m_ready = 1'b0;
    load_mem(0);
    #1;
    chk("rst_rd_en", bus.ram_rd_en, 0);
    chk("rst_rd_addr", bus.ram_rd_addr, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge ad_clk);
    @(negedge ad_clk);
    rst_n = 1'b1;

    // abort and cap_done together in IDLE: abort wins.
    @(posedge ad_clk); #1;
    cap_done = 1'b1; abort = 1'b1; trig_addr = 12'd600; bus.m_ready = 1'b1;
    #1;
    chk("idle_abort_rd_en", bus.ram_rd_en, 0);
    @(posedge ad_clk); #1;
    cap_done = 1'b0; abort = 1'b0;
    #1;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_rd_en2", bus.ram_rd_en, 0);

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    for (int i = 0; i < 3; i++) begin
      rt = int'($urandom_range(0, DEPTH - 1));
      rv = '{trig: 12'(rt), rnd_ready: 1, exp_start: (rt + DEPTH - DEPTH / 2) % DEPTH,
             exp_lat: 0, abort_at: 0, poke: 0, data_mode: 1};
      run_frame(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
